// File: rtl/mem_lsu_pkg.sv
// Shared types for the memory-stage LSU: op codes, FSM states, dcache request/response and result records.
// Pure declarations and helpers, no state.
package mem_lsu_pkg;

    localparam logic [7:0] EXE_ADD_OP   = 8'h01;
    localparam logic [7:0] EXE_LD_B_OP  = 8'h20;
    localparam logic [7:0] EXE_LD_H_OP  = 8'h21;
    localparam logic [7:0] EXE_LD_W_OP  = 8'h22;
    localparam logic [7:0] EXE_LD_BU_OP = 8'h23;
    localparam logic [7:0] EXE_LD_HU_OP = 8'h24;
    localparam logic [7:0] EXE_ST_B_OP  = 8'h25;
    localparam logic [7:0] EXE_ST_H_OP  = 8'h26;
    localparam logic [7:0] EXE_ST_W_OP  = 8'h27;
    localparam logic [7:0] EXE_LL_OP    = 8'h28;
    localparam logic [7:0] EXE_SC_OP    = 8'h29;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} lsu_state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dcache_req_struct;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } dcache_resp_struct;

    typedef struct packed {
        logic        vld;
        logic [4:0]  waddr;
        logic        wreg;
        logic [31:0] wdata;
        logic        llbit_we;
        logic        llbit_value;
        logic        excp_ale;
        logic        excp_up;
    } mem_result_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LD_B_OP, EXE_LD_H_OP, EXE_LD_W_OP, EXE_LD_BU_OP, EXE_LD_HU_OP, EXE_LL_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_ST_B_OP, EXE_ST_H_OP, EXE_ST_W_OP, EXE_SC_OP};
    endfunction

    function automatic mem_size_t op_size(input logic [7:0] op);
        if (op inside {EXE_LD_B_OP, EXE_LD_BU_OP, EXE_ST_B_OP}) return SZ_B;
        if (op inside {EXE_LD_H_OP, EXE_LD_HU_OP, EXE_ST_H_OP}) return SZ_H;
        return SZ_W;
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Narrow stores replicate their data across the word so the strobe alone selects the lane.
    function automatic dcache_req_struct enc_req(input logic [7:0] op, input logic [31:0] addr,
                                                 input logic [31:0] data);
        dcache_req_struct r;
        r.addr  = {addr[31:2], 2'b00};
        r.we    = is_store(op);
        r.wstrb = 4'h0;
        r.wdata = 32'h0;
        if (is_store(op)) begin
            case (op_size(op))
                SZ_B:    begin r.wstrb = 4'b0001 << addr[1:0];       r.wdata = {4{data[7:0]}};  end
                SZ_H:    begin r.wstrb = 4'b0011 << {addr[1], 1'b0}; r.wdata = {2{data[15:0]}}; end
                default: begin r.wstrb = 4'hF;                       r.wdata = data;            end
            endcase
        end
        return r;
    endfunction

    function automatic logic [7:0] diff_ld_bits(input logic [7:0] op);
        return {2'b00, op == EXE_LL_OP, op == EXE_LD_W_OP, op == EXE_LD_HU_OP,
                op == EXE_LD_H_OP, op == EXE_LD_BU_OP, op == EXE_LD_B_OP};
    endfunction

    function automatic logic [7:0] diff_st_bits(input logic [7:0] op);
        return {4'b0000, op == EXE_SC_OP, op == EXE_ST_W_OP, op == EXE_ST_H_OP, op == EXE_ST_B_OP};
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load data aligner: shifts the response word down by the byte offset and sign/zero-extends to 32 bits.
// Latency: combinational.
// Backpressure: none.
module lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        sext,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        case (size)
            SZ_B:    data = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_H:    data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one dcache access per memory op, one registered result per instruction; MEM_LSU_DIFFTEST_EN adds difftest outputs.
// Latency: result 1 cycle after accept for non-accesses, H+1 for stores, R+1 for loads (3 cycles minimum).
// Backpressure: ex_ready only in IDLE, stall_req otherwise; request fields held stable until dcache_req_ready.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_excp,
    input  logic        llbit,
    output logic        dcache_req_valid,
    input  logic        dcache_req_ready,
    output logic [31:0] dcache_req_addr,
    output logic        dcache_req_we,
    output logic [3:0]  dcache_req_wstrb,
    output logic [31:0] dcache_req_wdata,
    input  logic        dcache_resp_valid,
    input  logic [31:0] dcache_resp_rdata,
    output logic        mem_valid,
    output logic [4:0]  mem_waddr,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_llbit_we,
    output logic        mem_llbit_value,
    output logic        mem_excp_ale,
    output logic        mem_excp_up,
    output logic        stall_req
`ifdef MEM_LSU_DIFFTEST_EN
    ,
    output logic [7:0]  diff_ld_en,
    output logic [7:0]  diff_st_en,
    output logic [31:0] diff_vaddr,
    output logic [31:0] diff_st_data
`endif
);

    lsu_state_t        state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        waddr_q, waddr_d;
    logic              wreg_q, wreg_d;
    logic [31:0]       wdata_q, wdata_d;
    dcache_req_struct  req_q, req_d;
    mem_result_t       res_q, res_d;
    dcache_resp_struct resp;
    logic              req_vld;
    logic              ex_mem, ex_ale, ex_sc_fail, ex_short;
    mem_size_t         ld_size;
    logic              ld_sext;
    logic [31:0]       ld_data;

    assign resp       = '{valid: dcache_resp_valid, rdata: dcache_resp_rdata};
    assign ex_mem     = is_load(ex_aluop) || is_store(ex_aluop);
    assign ex_ale     = ex_mem && !ex_excp && misaligned(ex_aluop, ex_mem_addr[1:0]);
    assign ex_sc_fail = (ex_aluop == EXE_SC_OP) && !ex_excp && !ex_ale && !llbit;
    assign ex_short   = !ex_mem || ex_excp || ex_ale || ex_sc_fail;

    assign ld_size = op_size(op_q);
    assign ld_sext = (op_q == EXE_LD_B_OP) || (op_q == EXE_LD_H_OP);

    lsu_load_align u_load_align (
        .rdata  (resp.rdata),
        .offset (off_q),
        .size   (ld_size),
        .sext   (ld_sext),
        .data   (ld_data)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        res_d   = '0;
        req_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (ex_short) begin
                        res_d.vld      = 1'b1;
                        res_d.waddr    = ex_waddr;
                        res_d.wreg     = ex_wreg && !ex_ale;
                        res_d.wdata    = ex_sc_fail ? 32'h0 : ex_wdata;
                        res_d.excp_ale = ex_ale;
                        res_d.excp_up  = ex_excp;
                    end else begin
                        op_d    = ex_aluop;
                        off_d   = ex_mem_addr[1:0];
                        waddr_d = ex_waddr;
                        wreg_d  = ex_wreg;
                        wdata_d = ex_wdata;
                        req_d   = enc_req(ex_aluop, ex_mem_addr, ex_store_data);
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    req_vld = 1'b1;
                    if (dcache_req_ready) begin
                        if (is_load(op_q)) begin
                            state_d = RESP;
                        end else begin
                            res_d.vld      = 1'b1;
                            res_d.waddr    = waddr_q;
                            res_d.wreg     = wreg_q;
                            res_d.wdata    = (op_q == EXE_SC_OP) ? 32'd1 : wdata_q;
                            res_d.llbit_we = (op_q == EXE_SC_OP);
                            state_d        = IDLE;
                        end
                    end
                end
            end
            RESP: begin
                // A flush racing the response swallows it here; otherwise DRAIN waits for it.
                if (resp.valid) begin
                    state_d = IDLE;
                    if (!flush) begin
                        res_d.vld         = 1'b1;
                        res_d.waddr       = waddr_q;
                        res_d.wreg        = wreg_q;
                        res_d.wdata       = ld_data;
                        res_d.llbit_we    = (op_q == EXE_LL_OP);
                        res_d.llbit_value = (op_q == EXE_LL_OP);
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (resp.valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            req_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            res_q   <= res_d;
        end
    end

    assign ex_ready         = (state_q == IDLE);
    assign stall_req        = (state_q != IDLE);
    assign dcache_req_valid = req_vld;
    assign dcache_req_addr  = req_q.addr;
    assign dcache_req_we    = req_q.we;
    assign dcache_req_wstrb = req_q.wstrb;
    assign dcache_req_wdata = req_q.wdata;
    assign mem_valid        = res_q.vld;
    assign mem_waddr        = res_q.waddr;
    assign mem_wreg         = res_q.wreg;
    assign mem_wdata        = res_q.wdata;
    assign mem_llbit_we     = res_q.llbit_we;
    assign mem_llbit_value  = res_q.llbit_value;
    assign mem_excp_ale     = res_q.excp_ale;
    assign mem_excp_up      = res_q.excp_up;

`ifdef MEM_LSU_DIFFTEST_EN
    logic [31:0] vaddr_q, vaddr_d;
    logic [7:0]  diff_ld_en_q, diff_ld_en_d, diff_st_en_q, diff_st_en_d;
    logic [31:0] diff_vaddr_q, diff_vaddr_d, diff_st_data_q, diff_st_data_d;

    // Results produced outside IDLE are exactly the ones that performed an access.
    always_comb begin
        vaddr_d        = (state_q == IDLE) ? ex_mem_addr : vaddr_q;
        diff_ld_en_d   = '0;
        diff_st_en_d   = '0;
        diff_vaddr_d   = '0;
        diff_st_data_d = '0;
        if (res_d.vld && state_q != IDLE) begin
            diff_ld_en_d   = diff_ld_bits(op_q);
            diff_st_en_d   = diff_st_bits(op_q);
            diff_vaddr_d   = vaddr_q;
            diff_st_data_d = is_store(op_q) ? req_q.wdata : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vaddr_q        <= '0;
            diff_ld_en_q   <= '0;
            diff_st_en_q   <= '0;
            diff_vaddr_q   <= '0;
            diff_st_data_q <= '0;
        end else begin
            vaddr_q        <= vaddr_d;
            diff_ld_en_q   <= diff_ld_en_d;
            diff_st_en_q   <= diff_st_en_d;
            diff_vaddr_q   <= diff_vaddr_d;
            diff_st_data_q <= diff_st_data_d;
        end
    end

    assign diff_ld_en   = diff_ld_en_q;
    assign diff_st_en   = diff_st_en_q;
    assign diff_vaddr   = diff_vaddr_q;
    assign diff_st_data = diff_st_data_q;
`endif

endmodule
